pkt_write_arbiter: RTL

PKT_WRITE_ARBITER -- requirements
Module: pkt_write_arbiter

---
 rtl/pkt_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 45 ++++
 rtl/pkt_write_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pkt_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module   : pkt_arb_pkg
// Desc     : Shared state encoding and index-width helper for the write arbiter
// Revision : 1.0 - initial release
//==============================================================================
package pkt_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
//==============================================================================
// Module   : rr_pick
// Desc     : Round-robin one-hot picker; search begins one past i_ptr and wraps
// Revision : 1.0 - initial release
//==============================================================================
module rr_pick
    import pkt_arb_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;
    logic          w_found;

    // i_ptr < N and offset <= N, so one conditional subtract gives the modulo
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int off = 1; off <= N; off++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(off);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_idx = w_sum[IW-1:0];
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_write_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : pkt_write_arbiter
// Desc     : N-port packet arbiter (strict priority or WRR) with registered output
// Revision : 1.0 - initial release
//==============================================================================
module pkt_write_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 16,
    parameter int DATA_WIDTH   = 64,
    parameter int PRIO_WIDTH   = 3,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sp0_wrr1,
    input  logic [NUM_PORTS-1:0]               vld,
    input  logic [NUM_PORTS-1:0]               sop,
    input  logic [NUM_PORTS-1:0]               eop,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    data_in_p,
    input  logic [NUM_PORTS*PRIO_WIDTH-1:0]    prio_in_p,
    input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0]  weight_in_p,
    input  logic                               out_ready,
    output logic [NUM_PORTS-1:0]               ready,
    output logic                               out_vld,
    output logic                               out_sop,
    output logic                               out_eop,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [$clog2(NUM_PORTS)-1:0]       out_port,
    output logic                               busy
);

    localparam int C_IW = idx_w(NUM_PORTS);

    logic [DATA_WIDTH-1:0]   w_data   [NUM_PORTS];
    logic [PRIO_WIDTH-1:0]   w_prio   [NUM_PORTS];
    logic [WEIGHT_WIDTH-1:0] w_weight [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign w_data[gi]   = data_in_p[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_prio[gi]   = prio_in_p[gi*PRIO_WIDTH +: PRIO_WIDTH];
        assign w_weight[gi] = weight_in_p[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    arb_state_t              r_state, w_state_nxt;
    logic [C_IW-1:0]         r_last, r_gnt;
    logic [NUM_PORTS-1:0]    r_gnt_oh;
    logic                    r_lock_wrr;
    logic [WEIGHT_WIDTH-1:0] r_credit [NUM_PORTS];
    logic                    r_out_vld, r_out_sop, r_out_eop;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [C_IW-1:0]         r_out_port;

    logic [NUM_PORTS-1:0]    w_req, w_sp_cand, w_wrr_cand, w_cand, w_pick_oh;
    logic [PRIO_WIDTH-1:0]   w_max_prio;
    logic [C_IW-1:0]         w_pick_idx;
    logic                    w_any, w_reload, w_can_take, w_xfer;

    // SP candidates are the requesters at the top priority level; WRR needs credit
    always_comb begin
        w_req      = vld & sop;
        w_max_prio = '0;
        w_sp_cand  = '0;
        w_wrr_cand = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_req[i] && (w_prio[i] > w_max_prio)) begin
                w_max_prio = w_prio[i];
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_sp_cand[i]  = w_req[i] && (w_prio[i] == w_max_prio);
            w_wrr_cand[i] = w_req[i] && (r_credit[i] != '0);
        end
        w_cand = sp0_wrr1 ? w_wrr_cand : w_sp_cand;
    end

    rr_pick #(
        .N  (NUM_PORTS),
        .IW (C_IW)
    ) u_rr_pick (
        .i_req     (w_cand),
        .i_ptr     (r_last),
        .o_gnt     (w_pick_oh),
        .o_gnt_idx (w_pick_idx)
    );

    assign w_any      = |w_pick_oh;
    assign w_reload   = (r_state == ST_ARB) && sp0_wrr1 && (|w_req) && !(|w_wrr_cand);
    assign w_can_take = (r_state == ST_XFER) && (out_ready || !r_out_vld);
    assign w_xfer     = w_can_take && vld[r_gnt];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (|w_req) w_state_nxt = ST_ARB;
            ST_ARB:  w_state_nxt = w_any ? ST_XFER : ST_IDLE;
            ST_XFER: if (w_xfer && eop[r_gnt]) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_last     <= C_IW'(NUM_PORTS-1);
            r_gnt      <= '0;
            r_gnt_oh   <= '0;
            r_lock_wrr <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) r_credit[i] <= w_weight[i];
            r_out_vld  <= 1'b0;
            r_out_sop  <= 1'b0;
            r_out_eop  <= 1'b0;
            r_out_data <= '0;
            r_out_port <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_ARB) && w_any) begin
                r_last     <= w_pick_idx;
                r_gnt      <= w_pick_idx;
                r_gnt_oh   <= w_pick_oh;
                r_lock_wrr <= sp0_wrr1;
            end
            // Credits are spent once per WRR packet, when its last beat moves
            if (w_reload) begin
                for (int i = 0; i < NUM_PORTS; i++) r_credit[i] <= w_weight[i];
            end else if (w_xfer && eop[r_gnt] && r_lock_wrr) begin
                r_credit[r_gnt] <= r_credit[r_gnt] - WEIGHT_WIDTH'(1);
            end
            if (w_xfer) begin
                r_out_vld  <= 1'b1;
                r_out_sop  <= sop[r_gnt];
                r_out_eop  <= eop[r_gnt];
                r_out_data <= w_data[r_gnt];
                r_out_port <= r_gnt;
            end else if (out_ready) begin
                r_out_vld <= 1'b0;
                r_out_sop <= 1'b0;
                r_out_eop <= 1'b0;
            end
        end
    end

    assign ready    = w_can_take ? r_gnt_oh : '0;
    assign busy     = (r_state == ST_XFER);
    assign out_vld  = r_out_vld;
    assign out_sop  = r_out_sop;
    assign out_eop  = r_out_eop;
    assign out_data = r_out_data;
    assign out_port = r_out_port;

endmodule
`default_nettype wire
